// File: rtl/bus_sram_responder_pkg.sv
// Shared types for the bus-to-SRAM responder: bus field typedefs and the responder FSM state.
package bus_sram_responder_pkg;

    typedef logic [31:0] Word_t;
    typedef logic [31:0] BusAddr_t;
    typedef logic [3:0]  ByteEn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        DONE = 2'd3
    } BusRespState_t;

endpackage

// File: rtl/bus_sram_responder.sv
// Bus_if slave responder: dual-word reads and byte-masked writes against a
// single-port synchronous SRAM with one-cycle read latency.
module bus_sram_responder
    import bus_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter bit DUAL_WORD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  BusAddr_t              bus_address,
    input  logic                  bus_read,
    input  logic                  bus_write,
    input  ByteEn_t               bus_byteenable,
    input  Word_t                 bus_data_wr,
    output Word_t                 bus_data_rd,
    output Word_t                 bus_data_rd_2,
    output logic                  bus_stall,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output Word_t                 sram_wdata,
    input  Word_t                 sram_rdata
);

    BusRespState_t         state_r;
    BusRespState_t         next_state_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    Word_t                 data_rd_r;
    Word_t                 data_rd_2_r;
    logic                  addr_unused_s;

    assign word_addr_s   = bus_address[ADDR_WIDTH+1:2];
    assign addr_unused_s = ^{bus_address[31:ADDR_WIDTH+2], bus_address[1:0]};

    assign bus_data_rd   = data_rd_r;
    assign bus_data_rd_2 = data_rd_2_r;

    // State register, captured read word address and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            data_rd_r   <= 32'h0000_0000;
            data_rd_2_r <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                IDLE: begin
                    addr_r <= word_addr_s;
                end
                RD1: begin
                    data_rd_r <= sram_rdata;
                    if (!DUAL_WORD) begin
                        data_rd_2_r <= 32'h0000_0000;
                    end
                end
                RD2: begin
                    data_rd_2_r <= sram_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and SRAM/bus handshake decode; reset forces a quiet interface.
    always_comb begin
        next_state_s = state_r;
        bus_stall    = 1'b0;
        sram_en      = 1'b0;
        sram_we      = 4'b0000;
        sram_addr    = addr_r;
        sram_wdata   = bus_data_wr;
        case (state_r)
            IDLE: begin
                sram_addr = word_addr_s;
                // A simultaneous read+write is served as a write only.
                if (bus_write) begin
                    sram_en      = 1'b1;
                    sram_we      = bus_byteenable;
                    bus_stall    = 1'b1;
                    next_state_s = DONE;
                end else if (bus_read) begin
                    sram_en      = 1'b1;
                    bus_stall    = 1'b1;
                    next_state_s = RD1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD1: begin
                bus_stall = 1'b1;
                if (DUAL_WORD) begin
                    sram_en      = 1'b1;
                    sram_addr    = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    next_state_s = RD2;
                end else begin
                    next_state_s = DONE;
                end
            end
            RD2: begin
                bus_stall    = 1'b1;
                next_state_s = DONE;
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (rst) begin
            next_state_s = IDLE;
            bus_stall    = 1'b0;
            sram_en      = 1'b0;
            sram_we      = 4'b0000;
        end else begin
            next_state_s = next_state_s;
        end
    end

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
- Slave-side responder for the CPU's Bus_if master port (instruction or data side).
- Serves read requests as a dual-word fetch: word at the requested address on data_rd, next word on data_rd_2, matching the dual-issue fetch.
- Serves byte-masked single-word writes.
- Sits between the bus and a single-port synchronous SRAM with 1-cycle read latency, pacing the master via stall.

Parameters:
ADDR_WIDTH, 14, SRAM word-address width; capacity 2^ADDR_WIDTH 32-bit words.
DUAL_WORD, 1, 1 = read fetches two words; 0 = one word, data_rd_2 driven 0.

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; synchronous, active-high
bus_address  input  32  byte address; bits [1:0] ignored; bits above ADDR_WIDTH+1 ignored (aliasing)
bus_read  input  1  read request
bus_write  input  1  write request
bus_byteenable  input  4  write byte mask
bus_data_wr  input  32  write data
bus_data_rd  output  32  word at address
bus_data_rd_2  output  32  word at address+4
bus_stall  output  1  request not complete; master holds request stable
sram_addr  output  ADDR_WIDTH  word address
sram_en  output  1  SRAM access enable
sram_we  output  4  per-byte write enable
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid the cycle after sram_en with sram_we=0

Behaviour:
- FSM states: IDLE, RD1, RD2, DONE. Word address W = bus_address[ADDR_WIDTH+1:2].
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - word registers bus_data_rd and bus_data_rd_2 clear to 0.
  - While rst=1: bus_stall=0, sram_en=0, sram_we=0.
- Request present = bus_read | bus_write. If both are asserted, the request is a write; the read is ignored.
- IDLE:
  - No request: bus_stall=0, sram_en=0.
  - Write: sram_en=1, sram_we=bus_byteenable, sram_addr=W, sram_wdata=bus_data_wr, bus_stall=1, next DONE.
  - Read: sram_en=1, sram_we=0, sram_addr=W, bus_stall=1, next RD1.
- RD1:
  - Latch sram_rdata into bus_data_rd.
  - If DUAL_WORD: sram_en=1, sram_addr=W+1 (modulo 2^ADDR_WIDTH, so the top word wraps to 0), next RD2.
  - Otherwise: bus_data_rd_2 <= 0, next DONE.
  - bus_stall=1.
- RD2: latch sram_rdata into bus_data_rd_2; sram_en=0; bus_stall=1; next DONE.
- DONE: bus_stall=0; sram_en=0, sram_we=0; next IDLE unconditionally. A request still asserted in the following cycle is a new request.
- Latency:
  - Dual read: 3 stall cycles, data valid in the 4th (DONE) cycle.
  - Single read: 2 stall cycles.
  - Write: 1 stall cycle. The SRAM write is issued exactly once, in the IDLE cycle.
- bus_data_rd and bus_data_rd_2 are registered and hold their last values outside DONE.
- Byteenable 4'b0000 on a write: no bytes change, but full write timing still applies.
- Request deasserted while in RD1/RD2 (protocol violation): the FSM completes to DONE, then IDLE. No SRAM write is generated.
- Reset mid-operation: abort immediately to IDLE. No partial write is replayed.

Decomposition:
- Shared cpu package gets:
  - BusRespState_t enum {IDLE, RD1, RD2, DONE}.
  - Bus_if field typedefs, reusing Word_t.
- No RTL sub-module. The bench supplies a behavioural sync_sram_model with 1-cycle read latency and byte writes.

Test Plan:
- Reset: hold rst 2 cycles while bus_read=1 -> bus_stall=0, data_rd=data_rd_2=0, sram_en=0; first cycle after release starts RD1.
- Dual read: mem[0x40]=0x11111111, mem[0x41]=0x22222222, read 0x100 -> bus_stall=1,1,1,0; in DONE data_rd=0x11111111, data_rd_2=0x22222222.
- Wrap: ADDR_WIDTH=14, read 0xFFFC, mem[0x3FFF]=0xAAAA5555, mem[0]=0x0BADF00D -> data_rd=0xAAAA5555, data_rd_2=0x0BADF00D.
- Byte write: mem[0x10]=0xFFFFFFFF, write 0x40, data 0x12345678, byteenable 4'b0011 -> one cycle with sram_we=0011, stall pattern 1,0; later read returns 0xFFFF5678.
- Simultaneous read+write at 0x80 -> treated as a write (stall 1,0); the SRAM is never read for this request.
- Reset in RD1: rst asserted in the RD1 cycle -> next cycle IDLE, stall=0, data_rd=0; the next read completes normally.
